// File: rtl/eth_pcs_rx_gearbox_lock.sv
// eth_pcs_rx_gearbox_lock: 10GBASE-R RX gearbox with integrated block lock.
// Packs W_DATA-bit PMA words (bit 0 earliest) into 66b blocks and hunts for
// sync-header alignment by slipping one bit at a time.
// Optional build macro ETH_PCS_RX_GRBX_STATS_EN adds slip / lock-loss counters
// with a synchronous clear input.
module eth_pcs_rx_gearbox_lock #(
    parameter int W_DATA         = 32,
    parameter int SH_CNT_MAX     = 64,
    parameter int SH_INVALID_MAX = 16
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [W_DATA-1:0] i_pma_data,
`ifdef ETH_PCS_RX_GRBX_STATS_EN
    input  logic              i_stats_clr,
    output logic [15:0]       o_slip_cnt,
    output logic [15:0]       o_lock_loss_cnt,
`endif
    output logic              o_blk_valid,
    output logic [1:0]        o_blk_hdr,
    output logic [63:0]       o_blk_data,
    output logic              o_rx_lock,
    output logic              o_slip
);

    localparam int W_BUF = 66 + W_DATA;
    localparam int CNT_W = $clog2(SH_CNT_MAX + 1);
    localparam int INV_W = $clog2(SH_INVALID_MAX + 1);

    generate
        if (!(W_DATA == 16 || W_DATA == 32 || W_DATA == 64)) begin : g_bad_w_data
            $error("eth_pcs_rx_gearbox_lock: W_DATA must be 16, 32 or 64");
        end
    endgenerate

    typedef enum logic [1:0] {
        LOCK_INIT,
        TEST_SH,
        SLIP_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [W_BUF-1:0] acc_q, acc_d, word_ext, merged;
    logic [6:0]       fill_q, fill_d, word_len;
    logic [7:0]       total;
    logic             emit;
    logic             drop_q, drop_d;
    logic             slip_req, slip_applied_q, blk_post_q;
    logic             hdr_ok, lock_d;
    logic [CNT_W-1:0] sh_cnt_q, sh_cnt_d, sh_cnt_inc;
    logic [INV_W-1:0] sh_inv_q, sh_inv_d, sh_inv_inc;

    // Append the incoming word at the fill point, cut a block when 66 bits are
    // present, then apply a pending slip to whatever remains.
    always_comb begin
        word_ext = W_BUF'(i_pma_data);
        word_len = 7'(W_DATA);
        if (drop_q) begin
            word_ext = word_ext >> 1;
            word_len = 7'(W_DATA - 1);
        end
        merged = acc_q | (word_ext << fill_q);
        total  = {1'b0, fill_q} + {1'b0, word_len};
        emit   = (total >= 8'd66);
        acc_d  = merged;
        fill_d = total[6:0];
        if (emit) begin
            acc_d  = merged >> 66;
            fill_d = 7'(total - 8'd66);
        end
        drop_d = 1'b0;
        // An empty remainder defers the slip to bit 0 of the next word.
        if (o_slip) begin
            if (fill_d != 7'd0) begin
                acc_d  = acc_d >> 1;
                fill_d = fill_d - 7'd1;
            end else begin
                drop_d = 1'b1;
            end
        end
    end

    // Accumulator state and registered block outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            acc_q       <= '0;
            fill_q      <= '0;
            drop_q      <= 1'b0;
            o_blk_valid <= 1'b0;
            o_blk_hdr   <= '0;
            o_blk_data  <= '0;
            blk_post_q  <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            drop_q      <= drop_d;
            o_blk_valid <= emit;
            if (emit) begin
                o_blk_hdr  <= merged[1:0];
                o_blk_data <= merged[65:2];
                // Marks blocks cut entirely after the last requested slip took effect.
                blk_post_q <= slip_applied_q & ~slip_req;
            end
        end
    end

    // Block-lock next state: judge each emitted block's sync header.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        sh_inv_d   = sh_inv_q;
        lock_d     = o_rx_lock;
        slip_req   = 1'b0;
        hdr_ok     = o_blk_hdr[0] ^ o_blk_hdr[1];
        sh_cnt_inc = sh_cnt_q + CNT_W'(1);
        sh_inv_inc = sh_inv_q + {{(INV_W-1){1'b0}}, ~hdr_ok};
        case (state_q)
            LOCK_INIT: begin
                lock_d   = 1'b0;
                sh_cnt_d = '0;
                sh_inv_d = '0;
                state_d  = TEST_SH;
            end
            TEST_SH: begin
                if (o_blk_valid) begin
                    if (!o_rx_lock) begin
                        if (hdr_ok) begin
                            sh_inv_d = '0;
                            if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
                                lock_d   = 1'b1;
                                sh_cnt_d = '0;
                            end else begin
                                sh_cnt_d = sh_cnt_inc;
                            end
                        end else begin
                            slip_req = 1'b1;
                            lock_d   = 1'b0;
                            sh_cnt_d = '0;
                            sh_inv_d = '0;
                            state_d  = SLIP_WAIT;
                        end
                    end else if (sh_inv_inc == INV_W'(SH_INVALID_MAX)) begin
                        slip_req = 1'b1;
                        lock_d   = 1'b0;
                        sh_cnt_d = '0;
                        sh_inv_d = '0;
                        state_d  = SLIP_WAIT;
                    end else if (sh_cnt_inc == CNT_W'(SH_CNT_MAX)) begin
                        sh_cnt_d = '0;
                        sh_inv_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_inc;
                        sh_inv_d = sh_inv_inc;
                    end
                end
            end
            SLIP_WAIT: begin
                if (o_blk_valid && blk_post_q) begin
                    state_d = TEST_SH;
                end
            end
            default: state_d = LOCK_INIT;
        endcase
    end

    // Block-lock state register; o_slip marks the cycle the slip is applied.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q        <= LOCK_INIT;
            sh_cnt_q       <= '0;
            sh_inv_q       <= '0;
            o_rx_lock      <= 1'b0;
            o_slip         <= 1'b0;
            slip_applied_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sh_cnt_q  <= sh_cnt_d;
            sh_inv_q  <= sh_inv_d;
            o_rx_lock <= lock_d;
            o_slip    <= slip_req;
            if (slip_req) begin
                slip_applied_q <= 1'b0;
            end else if (o_slip) begin
                slip_applied_q <= 1'b1;
            end
        end
    end

`ifdef ETH_PCS_RX_GRBX_STATS_EN
    // Saturating statistics; clear wins over a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_slip_cnt      <= '0;
            o_lock_loss_cnt <= '0;
        end else if (i_stats_clr) begin
            o_slip_cnt      <= '0;
            o_lock_loss_cnt <= '0;
        end else begin
            if (o_slip && (o_slip_cnt != 16'hFFFF)) begin
                o_slip_cnt <= o_slip_cnt + 16'd1;
            end
            if (o_rx_lock && !lock_d && (o_lock_loss_cnt != 16'hFFFF)) begin
                o_lock_loss_cnt <= o_lock_loss_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
